// File: rtl/axi_timer_regs.sv
// Machine timer: prescaled free-running mtime, software mtimecmp, and a
// single-outstanding valid/ready register port. Time and IRQ outputs are registered.
module axi_timer_regs #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_i,
  input  logic        reg_req_valid_i,
  output logic        reg_req_ready_o,
  input  logic        reg_req_we_i,
  input  logic [3:0]  reg_req_addr_i,
  input  logic [63:0] reg_req_wdata_i,
  input  logic [7:0]  reg_req_be_i,
  output logic        reg_resp_valid_o,
  input  logic        reg_resp_ready_i,
  output logic [63:0] reg_resp_rdata_o,
  output logic        reg_resp_err_o,
  output logic [63:0] time_o,
  output logic        time_irq_o
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       ADDR_MTIME = 4'h0;
  localparam logic [3:0]       ADDR_CMP   = 4'h8;
  localparam logic [63:0]      CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } port_state_t;

  port_state_t r_state;
  port_state_t w_state_nxt;

  logic [CNT_W-1:0] r_presc;
  logic [63:0]      r_mtime;
  logic [63:0]      r_mtimecmp;
  logic [63:0]      r_time;
  logic             r_irq;
  logic [63:0]      r_resp_rdata;
  logic             r_resp_err;

  logic             w_tick;
  logic             w_accept;
  logic             w_hit_mtime;
  logic             w_hit_cmp;
  logic             w_mapped;
  logic             w_wr_mtime;
  logic             w_wr_cmp;
  logic [63:0]      w_be_mask;
  logic [63:0]      w_mtime_inc;
  logic [63:0]      w_mtime_nxt;
  logic [63:0]      w_cmp_nxt;
  logic [63:0]      w_rdata;
  logic [CNT_W-1:0] w_presc_nxt;

  function automatic logic [63:0] be_to_mask(input logic [7:0] be);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [63:0] mask);
    return (new_val & mask) | (old_val & ~mask);
  endfunction

  // Request decode and prescaler
  always_comb begin
    w_accept    = reg_req_valid_i && (r_state == ST_IDLE);
    w_hit_mtime = (reg_req_addr_i == ADDR_MTIME);
    w_hit_cmp   = (reg_req_addr_i == ADDR_CMP);
    w_mapped    = w_hit_mtime || w_hit_cmp;
    w_wr_mtime  = w_accept && reg_req_we_i && w_hit_mtime;
    w_wr_cmp    = w_accept && reg_req_we_i && w_hit_cmp;
    w_be_mask   = be_to_mask(reg_req_be_i);

    w_tick      = !halt_i && (r_presc == PRESC_LAST);
    w_presc_nxt = r_presc;
    if (!halt_i) begin
      w_presc_nxt = w_tick ? '0 : r_presc + CNT_W'(1);
    end
  end

  // A same-cycle software write overrides only the enabled bytes of the ticked value.
  always_comb begin
    w_mtime_inc = r_mtime + 64'(w_tick);
    w_mtime_nxt = w_mtime_inc;
    if (w_wr_mtime) begin
      w_mtime_nxt = byte_merge(w_mtime_inc, reg_req_wdata_i, w_be_mask);
    end

    w_cmp_nxt = r_mtimecmp;
    if (w_wr_cmp) begin
      w_cmp_nxt = byte_merge(r_mtimecmp, reg_req_wdata_i, w_be_mask);
    end

    w_rdata = '0;
    if (!reg_req_we_i) begin
      if (w_hit_mtime) begin
        w_rdata = r_mtime;
      end else if (w_hit_cmp) begin
        w_rdata = r_mtimecmp;
      end
    end
  end

  // Register port handshake FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (reg_req_valid_i)  w_state_nxt = ST_RESP;
      ST_RESP: if (reg_resp_ready_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response capture: held stable until the response handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_rdata <= w_rdata;
      r_resp_err   <= !w_mapped;
    end
  end

  // Timer state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= CMP_RST;
      r_time     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_time     <= r_mtime;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

  assign reg_req_ready_o  = (r_state == ST_IDLE);
  assign reg_resp_valid_o = (r_state == ST_RESP);
  assign reg_resp_rdata_o = r_resp_rdata;
  assign reg_resp_err_o   = r_resp_err;
  assign time_o           = r_time;
  assign time_irq_o       = r_irq;

endmodule

// File: doc/axi_timer_regs.md
Name: axi_timer_regs

Overview:
- Machine-timer block sitting directly upstream of the core wrapper. It drives the wrapper's 64-bit time value and its timer-interrupt input.
- It holds a free-running mtime counter, advanced by a clock prescaler, and a software-writable mtimecmp register.
- Both registers are reachable through a simple single-outstanding valid/ready register port, which the FPGA peripheral interconnect drives.
- Time and IRQ outputs are fully registered.

Parameters:
- TICK_DIV, 50, clock cycles per mtime increment; must be >= 1 (1 = increment every cycle).
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- halt_i  in  1  debug halt; freezes prescaler and mtime while high
- reg_req_valid_i  in  1  register request valid
- reg_req_ready_o  out  1  register request ready
- reg_req_we_i  in  1  1 = write, 0 = read
- reg_req_addr_i  in  4  byte offset: 0x0 = mtime, 0x8 = mtimecmp
- reg_req_wdata_i  in  64  write data
- reg_req_be_i  in  8  byte enables for writes
- reg_resp_valid_o  out  1  response valid
- reg_resp_ready_i  in  1  response accepted
- reg_resp_rdata_o  out  64  read data; 0 for writes and errors
- reg_resp_err_o  out  1  unmapped offset
- time_o  out  64  current mtime, to the core wrapper time input
- time_irq_o  out  1  mtime >= mtimecmp, to the core wrapper timer-IRQ input

Behaviour:
- Reset values:
  - prescaler = 0, mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - time_o = 0, time_irq_o = 0.
  - reg_req_ready_o = 1, reg_resp_valid_o = 0, reg_resp_rdata_o = 0, reg_resp_err_o = 0.
- Prescaler:
  - When halt_i = 0 and prescaler == TICK_DIV-1: prescaler <= 0 and mtime <= mtime + 1 (tick).
  - Otherwise, when halt_i = 0: prescaler increments.
  - halt_i = 1 holds both prescaler and mtime.
  - mtime wraps from 2^64-1 to 0 with no flag.
- time_o: register copy of mtime. It reflects a tick or write one cycle after mtime updates.
- time_irq_o: registered compare, time_irq_o <= (mtime >= mtimecmp), unsigned, evaluated every cycle including during halt. It is level, not pulse; it clears one cycle after mtimecmp is raised above mtime.
- Register port handshake:
  - A request is accepted on valid & ready.
  - Ready drops the cycle after acceptance and stays low until the response handshake (resp_valid & resp_ready) completes.
  - Response valid asserts exactly one cycle after acceptance.
  - Ready rises the cycle after the response handshake, so back-to-back throughput is 1 request per 2 cycles when resp_ready_i is held high.
  - Response fields are held stable while resp_valid_o = 1 and resp_ready_i = 0.
- Reads:
  - rdata is sampled at acceptance: mtime or mtimecmp value before any same-cycle tick.
- Writes:
  - Byte-granular per reg_req_be_i; be = 0 is a legal no-op that still returns a response.
  - A write to mtime in the same cycle as a tick: the write wins for enabled bytes; disabled bytes take the ticked value. Prescaler is unaffected by the write.
  - A write to mtimecmp takes effect on the next cycle's compare.
- Unmapped offsets:
  - Any addr other than 0x0 or 0x8, including 0x4 and 0xC, is unmapped.
  - Writes have no effect; reads return 0; reg_resp_err_o = 1.
- Reset mid-transaction: a pending response is dropped (resp_valid_o = 0 next cycle) and all state returns to reset values.
- TICK_DIV = 1: mtime increments every unhalted cycle.

Test Plan:
- Reset, TICK_DIV = 4, halt_i = 0, 40 cycles → time_o reaches 10 (±1 for register delay); time_irq_o stays 0.
- Write mtimecmp = 5 (be = 8'hFF), TICK_DIV = 4 → time_irq_o rises the cycle after mtime becomes 5; then write mtimecmp = 100 → time_irq_o falls the cycle after.
- Write mtime = 64'hFFFF_FFFF_FFFF_FFFE, let 2 ticks pass → time_o = 0 after wrap; with mtimecmp = all-ones, time_irq_o is 1 during mtime = all-ones and 0 after the wrap.
- Partial write to mtime with be = 8'h01, wdata low byte 0xAB, while mtime = 0x1234, with no tick that cycle → mtime = 0x12AB; read back returns 0x12AB plus ticks since.
- Read addr 0x4 → resp_err_o = 1, rdata = 0; hold resp_ready_i = 0 for 3 cycles → response stable, req_ready_o = 0 throughout; then ready rises 1 cycle after the handshake.
- halt_i = 1 for 20 cycles at TICK_DIV = 4 → time_o constant; write mtimecmp = 0 during halt → time_irq_o = 1 within 2 cycles.
- Assert rst_i while a read response is pending → resp_valid_o = 0 and time_o = 0 next cycle; mtimecmp reads back all-ones.
